// File: rtl/mat_addr_gen_pkg.sv
// Shared definitions for the matrix-multiply operand address sequencer.
// Holds width defaults, the sequencer state type and a beat-count helper.
package mat_addr_gen_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DIM_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   // Number of operand beats a full N x K x P walk produces.
   function automatic int unsigned beat_count(input int unsigned n,
                                              input int unsigned k,
                                              input int unsigned p);
      return n * k * p;
   endfunction

endpackage

// File: rtl/mag_wrap_cnt.sv
// Loop index counter for the address walk: clears, advances on enable and
// wraps back to zero after reaching limit-1.
module mag_wrap_cnt
   import mat_addr_gen_pkg::*;
#(
   parameter int DIM_W = DIM_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [DIM_W-1:0] i_limit,
   output logic [DIM_W-1:0] o_count,
   output logic             o_is_max
);

   logic [DIM_W-1:0] r_count;

   assign o_is_max = (r_count == (i_limit - DIM_W'(1)));
   assign o_count  = r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= o_is_max ? '0 : r_count + DIM_W'(1);
      end
   end

endmodule

// File: rtl/mat_addr_gen.sv
// Operand address sequencer: walks row-major A, B and C with adders only and
// emits one (a_addr, b_addr) pair per MAC beat. Optional: MAT_ADDR_GEN_STALL_CNT_EN.
module mat_addr_gen
   import mat_addr_gen_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = DIM_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
   input  logic [ADDR_W-1:0] c_base,
   input  logic [DIM_W-1:0]  dim_n,
   input  logic [DIM_W-1:0]  dim_k,
   input  logic [DIM_W-1:0]  dim_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   output logic [ADDR_W-1:0] c_addr,
   output logic              dot_last,
   output logic              busy,
   output logic              done
`ifdef MAT_ADDR_GEN_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   state_e r_state;
   state_e w_next;

   logic              r_done;
   logic [DIM_W-1:0]  r_dim_n, r_dim_k, r_dim_p;
   logic [ADDR_W-1:0] r_b_base;
   logic [ADDR_W-1:0] r_a_row, r_a_ptr, r_b_col, r_b_ptr, r_c_ptr;

   logic w_start_ok, w_zero_dim, w_accept;
   logic w_t_max, w_j_max, w_i_max;
   logic [DIM_W-1:0] w_t, w_j, w_i;
   logic [ADDR_W-1:0] w_k_step, w_p_step;

   // The done cycle still counts as busy, so a start there is ignored too.
   assign w_start_ok = start && (r_state == IDLE) && !r_done;
   assign w_zero_dim = (dim_n == '0) || (dim_k == '0) || (dim_p == '0);
   assign w_accept   = (r_state == RUN) && out_ready;
   assign w_k_step   = ADDR_W'(r_dim_k);
   assign w_p_step   = ADDR_W'(r_dim_p);

   assign out_valid = (r_state == RUN);
   assign dot_last  = out_valid && w_t_max;
   assign busy      = (r_state != IDLE) || r_done;
   assign done      = r_done;
   assign a_addr    = r_a_ptr;
   assign b_addr    = r_b_ptr;
   assign c_addr    = r_c_ptr;

   mag_wrap_cnt #(.DIM_W(DIM_W)) u_cnt_t (
      .clk(clk), .reset(reset), .i_clr(w_start_ok), .i_en(w_accept),
      .i_limit(r_dim_k), .o_count(w_t), .o_is_max(w_t_max)
   );

   mag_wrap_cnt #(.DIM_W(DIM_W)) u_cnt_j (
      .clk(clk), .reset(reset), .i_clr(w_start_ok), .i_en(w_accept && w_t_max),
      .i_limit(r_dim_p), .o_count(w_j), .o_is_max(w_j_max)
   );

   mag_wrap_cnt #(.DIM_W(DIM_W)) u_cnt_i (
      .clk(clk), .reset(reset), .i_clr(w_start_ok),
      .i_en(w_accept && w_t_max && w_j_max),
      .i_limit(r_dim_n), .o_count(w_i), .o_is_max(w_i_max)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == FIN);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_start_ok) w_next = w_zero_dim ? FIN : RUN;
         RUN:  if (w_accept && w_t_max && w_j_max && w_i_max) w_next = FIN;
         FIN:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Pointer walk: inner step along a row of A / column of B, then rewind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dim_n  <= '0;
         r_dim_k  <= '0;
         r_dim_p  <= '0;
         r_b_base <= '0;
         r_a_row  <= '0;
         r_a_ptr  <= '0;
         r_b_col  <= '0;
         r_b_ptr  <= '0;
         r_c_ptr  <= '0;
      end else if (w_start_ok) begin
         r_dim_n  <= dim_n;
         r_dim_k  <= dim_k;
         r_dim_p  <= dim_p;
         r_b_base <= b_base;
         r_a_row  <= a_base;
         r_a_ptr  <= a_base;
         r_b_col  <= b_base;
         r_b_ptr  <= b_base;
         r_c_ptr  <= c_base;
      end else if (w_accept) begin
         if (!w_t_max) begin
            r_a_ptr <= r_a_ptr + ADDR_W'(1);
            r_b_ptr <= r_b_ptr + w_p_step;
         end else if (!w_j_max) begin
            r_a_ptr <= r_a_row;
            r_b_col <= r_b_col + ADDR_W'(1);
            r_b_ptr <= r_b_col + ADDR_W'(1);
            r_c_ptr <= r_c_ptr + ADDR_W'(1);
         end else if (!w_i_max) begin
            r_a_row <= r_a_row + w_k_step;
            r_a_ptr <= r_a_row + w_k_step;
            r_b_col <= r_b_base;
            r_b_ptr <= r_b_base;
            r_c_ptr <= r_c_ptr + ADDR_W'(1);
         end
      end
   end

`ifdef MAT_ADDR_GEN_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_start_ok) begin
         r_stall_cnt <= '0;
      end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

   logic w_unused;
   assign w_unused = ^{w_t, w_j, w_i};

endmodule

// File: tb/tb_mat_addr_gen.sv
// Self-checking bench for mat_addr_gen: directed scenarios plus random
// configurations compared against a nested-loop reference of the address walk.
module tb_mat_addr_gen;
   import mat_addr_gen_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      logic [AW-1:0] c;
      logic [DW-1:0] n;
      logic [DW-1:0] k;
      logic [DW-1:0] p;
   } cfg_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] a_base, b_base, c_base;
   logic [DW-1:0] dim_n, dim_k, dim_p;
   logic          out_valid, out_ready;
   logic [AW-1:0] a_addr, b_addr, c_addr;
   logic          dot_last, busy, done;
`ifdef MAT_ADDR_GEN_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   mat_addr_gen #(.ADDR_W(AW), .DIM_W(DW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .a_base(a_base), .b_base(b_base), .c_base(c_base),
      .dim_n(dim_n), .dim_k(dim_k), .dim_p(dim_p),
      .out_valid(out_valid), .out_ready(out_ready),
      .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
      .dot_last(dot_last), .busy(busy), .done(done)
`ifdef MAT_ADDR_GEN_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // readyMode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
   // abortAt >= 0 pulls reset low while that beat (0-based) is presented.
   task automatic applyStimulus(input cfg_t cfg, input int readyMode,
                                input int abortAt, input bit midStart);
      logic [AW-1:0] expA[$];
      logic [AW-1:0] expB[$];
      logic [AW-1:0] expC[$];
      bit            expLast[$];
      int total, idx, cyc, stalls, budget;
      bit rdy;

      for (int i = 0; i < int'(cfg.n); i++)
         for (int j = 0; j < int'(cfg.p); j++)
            for (int t = 0; t < int'(cfg.k); t++) begin
               expA.push_back(AW'(int'(cfg.a) + i * int'(cfg.k) + t));
               expB.push_back(AW'(int'(cfg.b) + t * int'(cfg.p) + j));
               expC.push_back(AW'(int'(cfg.c) + i * int'(cfg.p) + j));
               expLast.push_back(t == int'(cfg.k) - 1);
            end
      total  = expA.size();
      budget = 4 * int'(beat_count(cfg.n, cfg.k, cfg.p)) + 20;

      @(negedge clk);
      a_base = cfg.a; b_base = cfg.b; c_base = cfg.c;
      dim_n  = cfg.n; dim_k  = cfg.k; dim_p  = cfg.p;
      start  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      start  = 1'b0;
      a_base = AW'($urandom); b_base = AW'($urandom); c_base = AW'($urandom);
      dim_n  = DW'($urandom); dim_k  = DW'($urandom); dim_p  = DW'($urandom);

      idx = 0; cyc = 0; stalls = 0;
      while (idx < total && cyc < budget) begin
         checkOutput("out_valid", out_valid, 1);
         checkOutput("busy_run", busy, 1);
         checkOutput("done_run", done, 0);
         checkOutput("a_addr", a_addr, expA[idx]);
         checkOutput("b_addr", b_addr, expB[idx]);
         checkOutput("dot_last", dot_last, expLast[idx]);
         if (expLast[idx]) checkOutput("c_addr", c_addr, expC[idx]);
         if (abortAt == idx) begin
            #2 reset = 1'b0;
            #1;
            checkOutput("rst_valid", out_valid, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_dot_last", dot_last, 0);
            checkOutput("rst_a_addr", a_addr, 0);
            checkOutput("rst_b_addr", b_addr, 0);
            checkOutput("rst_c_addr", c_addr, 0);
            repeat (3) begin
               @(negedge clk);
               checkOutput("rst_no_done", done, 0);
            end
            reset = 1'b1;
            return;
         end
         if (midStart && cyc == 2) begin
            start  = 1'b1;
            a_base = 16'h5555; b_base = 16'h6666; c_base = 16'h7777;
            dim_n  = 16'd1;    dim_k  = 16'd1;    dim_p  = 16'd1;
         end else begin
            start = 1'b0;
         end
         case (readyMode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         if (rdy) idx++;
         else     stalls++;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      if (idx < total) checkOutput("beat_budget", idx, total);

      checkOutput("fin_valid", out_valid, 0);
      checkOutput("fin_busy", busy, 1);
      checkOutput("fin_done", done, 0);
      @(negedge clk);
      checkOutput("done_pulse", done, 1);
      checkOutput("done_busy", busy, 1);
      checkOutput("done_valid", out_valid, 0);
`ifdef MAT_ADDR_GEN_STALL_CNT_EN
      checkOutput("stall_cnt", stall_cnt, stalls);
`endif
      @(negedge clk);
      checkOutput("done_clear", done, 0);
      checkOutput("idle_busy", busy, 0);
   endtask

   initial begin
      cfg_t cfg1, cfg;
      cfg1 = '{a: 16'h0000, b: 16'h0100, c: 16'h0200, n: 16'd2, k: 16'd3, p: 16'd2};

      reset = 1'b0; start = 1'b0; out_ready = 1'b0;
      a_base = '0; b_base = '0; c_base = '0;
      dim_n = '0; dim_k = '0; dim_p = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_valid", out_valid, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_dot_last", dot_last, 0);
      checkOutput("reset_a_addr", a_addr, 0);
      checkOutput("reset_b_addr", b_addr, 0);
      checkOutput("reset_c_addr", c_addr, 0);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] basic 2x3x2 walk");
      applyStimulus(cfg1, 0, -1, 1'b0);

      $display("[TB] same walk with backpressure");
      applyStimulus(cfg1, 1, -1, 1'b0);

      $display("[TB] zero inner dimension");
      cfg = '{a: 16'h0010, b: 16'h0020, c: 16'h0030, n: 16'd4, k: 16'd0, p: 16'd4};
      applyStimulus(cfg, 0, -1, 1'b0);

      $display("[TB] address wrap");
      cfg = '{a: 16'hFFFE, b: 16'hFFFD, c: 16'h1234, n: 16'd1, k: 16'd4, p: 16'd1};
      applyStimulus(cfg, 0, -1, 1'b0);

      $display("[TB] start while busy is ignored");
      applyStimulus(cfg1, 0, -1, 1'b1);

      $display("[TB] reset during beat 5, then full rerun");
      applyStimulus(cfg1, 0, 4, 1'b0);
      applyStimulus(cfg1, 0, -1, 1'b0);

      $display("[TB] random configurations");
      for (int r = 0; r < 10; r++) begin
         cfg.a = AW'($urandom);
         cfg.b = AW'($urandom);
         cfg.c = AW'($urandom);
         cfg.n = DW'($urandom_range(1, 3));
         cfg.k = DW'($urandom_range(0, 4));
         cfg.p = DW'($urandom_range(1, 3));
         applyStimulus(cfg, 2, -1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
